// File: rtl/spi_regif_sampled.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spi_regif_sampled                                             |
// | Purpose  : SPI slave register-access port, oversampled in the clk domain.|
// |            Decodes a command word (R/W bit + ADDR_W address) and a DATA_W |
// |            data word; issues a one-clk write strobe, or a read request   |
// |            followed by MSB-first shift-out on MISO.                      |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            i_sclk, i_mosi, i_cs_n  - SPI pins (asynchronous to clk)      |
// |            o_miso, o_miso_oe       - SPI data out and its enable         |
// |            o_reg_addr, o_wr_data, o_wr_en, o_rd_en, i_rd_data            |
// |                                    - register file side                  |
// |            o_frame_err             - one-clk pulse on an aborted frame   |
// | Options  : SPI_BURST_EN - multi-word frames with address auto-increment |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module spi_regif_sampled #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sclk,
  input  logic              i_mosi,
  input  logic              i_cs_n,
  output logic              o_miso,
  output logic              o_miso_oe,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_wr_en,
  output logic              o_rd_en,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_frame_err
);

  localparam int   CMD_W     = 1 + ADDR_W;
  localparam int   MAX_W     = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int   CNT_W     = $clog2(MAX_W + 1);
  localparam logic SCLK_IDLE = (CPOL != 0);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    HOLD = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;
  logic [CNT_W-1:0]       r_cnt;
  logic [MAX_W-2:0]       r_shift;
  logic [DATA_W-1:0]      r_tx;

  logic w_sclk, w_mosi, w_cs_n;
  logic w_rise, w_fall, w_lead, w_trail, w_sample, w_launch;
  logic w_cs_fall, w_cs_rise;
  logic [MAX_W-1:0] w_shift_in;
  logic w_cmd_done, w_word_done, w_rd_fire, w_wr_fire, w_frame_err;

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_n = r_cs_sync[SYNC_STAGES-1];

  assign w_rise    = w_sclk & ~r_sclk_d;
  assign w_fall    = ~w_sclk & r_sclk_d;
  assign w_lead    = (CPOL == 0) ? w_rise : w_fall;
  assign w_trail   = (CPOL == 0) ? w_fall : w_rise;
  assign w_sample  = (CPHA == 0) ? w_lead : w_trail;
  assign w_launch  = (CPHA == 0) ? w_trail : w_lead;
  assign w_cs_fall = ~w_cs_n & r_cs_d;
  assign w_cs_rise = w_cs_n & ~r_cs_d;

  assign w_shift_in = {r_shift, w_mosi};
  assign o_miso_oe  = ~w_cs_n;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // RD counts sample edges rather than launch edges so the last data bit is
  // still on the pin when the master samples it; the launch/sample pairing is
  // one-to-one in both phases, so this ends the word after DATA_W launches.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_done  = 1'b0;
    w_word_done = 1'b0;
    w_rd_fire   = 1'b0;
    w_wr_fire   = 1'b0;
    w_frame_err = 1'b0;
    if (w_cs_rise) begin
      w_state_nxt = IDLE;
      if ((r_state == CMD || r_state == RD || r_state == WR) && (r_cnt != '0))
        w_frame_err = 1'b1;
    end else begin
      case (r_state)
        IDLE: if (w_cs_fall) w_state_nxt = CMD;
        CMD: begin
          if (w_sample && r_cnt == CNT_W'(CMD_W - 1)) begin
            w_cmd_done = 1'b1;
            if (w_shift_in[CMD_W-1]) begin
              w_state_nxt = RD;
              w_rd_fire   = 1'b1;
            end else begin
              w_state_nxt = WR;
            end
          end
        end
        RD: begin
          if (w_sample && r_cnt == CNT_W'(DATA_W - 1)) begin
            w_word_done = 1'b1;
`ifdef SPI_BURST_EN
            w_rd_fire   = 1'b1;
`else
            w_state_nxt = HOLD;
`endif
          end
        end
        WR: begin
          if (w_sample && r_cnt == CNT_W'(DATA_W - 1)) begin
            w_word_done = 1'b1;
            w_wr_fire   = 1'b1;
`ifdef SPI_BURST_EN
            w_state_nxt = WR;
`else
            w_state_nxt = HOLD;
`endif
          end
        end
        default: ;  // HOLD waits for cs_n to deassert
      endcase
    end
  end

  // Datapath. The cs_n chain resets to the deasserted level and sclk to its
  // idle level so that reset release never produces a spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_d    <= SCLK_IDLE;
      r_cs_d      <= 1'b1;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_tx        <= '0;
      o_miso      <= 1'b0;
      o_reg_addr  <= '0;
      o_wr_data   <= '0;
      o_wr_en     <= 1'b0;
      o_rd_en     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs_n;
      o_rd_en     <= w_rd_fire;
      o_wr_en     <= w_wr_fire;
      o_frame_err <= w_frame_err;

      if (w_cs_rise) begin
        r_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: r_cnt <= '0;
          CMD: begin
            if (w_sample) begin
              r_shift <= w_shift_in[MAX_W-2:0];
              r_cnt   <= w_cmd_done ? '0 : r_cnt + CNT_W'(1);
              if (w_cmd_done) o_reg_addr <= w_shift_in[ADDR_W-1:0];
            end
          end
          WR: begin
            if (w_sample) begin
              r_shift <= w_shift_in[MAX_W-2:0];
              r_cnt   <= w_word_done ? '0 : r_cnt + CNT_W'(1);
              if (w_word_done) o_wr_data <= w_shift_in[DATA_W-1:0];
            end
          end
          RD: begin
            if (w_launch) begin
              o_miso <= r_tx[DATA_W-1];
              r_tx   <= r_tx << 1;
            end
            if (w_sample) r_cnt <= w_word_done ? '0 : r_cnt + CNT_W'(1);
          end
          default: ;
        endcase
      end

      // rd_data is captured on the edge that ends the rd_en cycle.
      if (o_rd_en) r_tx <= i_rd_data;

`ifdef SPI_BURST_EN
      // Write address advances as wr_en retires, so it is stable during the
      // strobe; read address advances before the next rd_en is issued.
      if (o_wr_en) o_reg_addr <= o_reg_addr + ADDR_W'(1);
      if (r_state == RD && w_word_done) o_reg_addr <= o_reg_addr + ADDR_W'(1);
`endif

      if (w_state_nxt != RD) o_miso <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_regif_sampled.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_spi_regif_sampled                                          |
// | Purpose  : Scoreboard bench for spi_regif_sampled. u_m1 uses the default |
// |            mode 1; u_m0 uses CPOL=0/CPHA=0. Expected register-side      |
// |            events are queued by the stimulus and popped by a monitor.    |
// | Options  : SPI_BURST_EN selects burst expectations                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_spi_regif_sampled;

  localparam int HP = 80;  // SCLK half period: 8 clk periods

  localparam logic [1:0] K_WR  = 2'd1;
  localparam logic [1:0] K_RD  = 2'd2;
  localparam logic [1:0] K_ERR = 2'd3;

  typedef struct packed {
    logic       dut;
    logic [1:0] kind;
    logic [6:0] addr;
    logic [7:0] data;
  } ev_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk  = 1'b0;
  logic       mosi  = 1'b0;
  logic [1:0] cs_n  = 2'b11;
  logic [7:0] rd_val = 8'h00;
  logic [1:0] miso, miso_oe, wr_en, rd_en, frame_err;
  logic [6:0] reg_addr [2];
  logic [7:0] wr_data  [2];
  logic [23:0] rx;

  int n_vec = 0;
  int n_err = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  spi_regif_sampled u_m1 (
    .clk(clk), .rst_n(rst_n), .i_sclk(sclk), .i_mosi(mosi), .i_cs_n(cs_n[0]),
    .o_miso(miso[0]), .o_miso_oe(miso_oe[0]), .o_reg_addr(reg_addr[0]),
    .o_wr_data(wr_data[0]), .o_wr_en(wr_en[0]), .o_rd_en(rd_en[0]),
    .i_rd_data(rd_val), .o_frame_err(frame_err[0])
  );

  spi_regif_sampled #(.CPOL(0), .CPHA(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .i_sclk(sclk), .i_mosi(mosi), .i_cs_n(cs_n[1]),
    .o_miso(miso[1]), .o_miso_oe(miso_oe[1]), .o_reg_addr(reg_addr[1]),
    .o_wr_data(wr_data[1]), .o_wr_en(wr_en[1]), .o_rd_en(rd_en[1]),
    .i_rd_data(rd_val), .o_frame_err(frame_err[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic d, input logic [1:0] k, input logic [6:0] a,
                      input logic [7:0] dt);
    ev_t e;
    e.dut = d; e.kind = k; e.addr = a; e.data = dt;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input ev_t act);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL event: unexpected dut%0d kind%0d addr %h data %h",
               act.dut, act.kind, act.addr, act.data);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        n_err++;
        $display("FAIL event: got dut%0d kind%0d addr %h data %h expected dut%0d kind%0d addr %h data %h",
                 act.dut, act.kind, act.addr, act.data, e.dut, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: sampled on the falling clk edge, away from the active edge.
  always @(negedge clk) begin
    ev_t a;
    for (int d = 0; d < 2; d++) begin
      if (wr_en[d]) begin
        a.dut = d[0]; a.kind = K_WR; a.addr = reg_addr[d]; a.data = wr_data[d];
        check_ev(a);
      end
      if (rd_en[d]) begin
        a.dut = d[0]; a.kind = K_RD; a.addr = reg_addr[d]; a.data = 8'h00;
        check_ev(a);
      end
      if (frame_err[d]) begin
        a.dut = d[0]; a.kind = K_ERR; a.addr = 7'h00; a.data = 8'h00;
        check_ev(a);
      end
    end
  end

  // SPI master, CPOL=0. MISO is sampled just before the master's sample edge.
  task automatic spi_xfer(input int d, input bit cpha, input int nbits,
                          input logic [23:0] tx, input bit end_cs,
                          output logic [23:0] rxo);
    rxo = '0;
    cs_n[d] = 1'b0;
    #(HP);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi = tx[i];
        #(HP);
        rxo  = {rxo[22:0], miso[d]};
        sclk = 1'b1;
        #(HP);
        sclk = 1'b0;
      end else begin
        sclk = 1'b1;
        mosi = tx[i];
        #(HP);
        rxo  = {rxo[22:0], miso[d]};
        sclk = 1'b0;
        #(HP);
      end
    end
    #(HP);
    if (end_cs) cs_n[d] = 1'b1;
    #(4 * HP);
  endtask

  task automatic drain(input string name);
    #(200);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, "_miso"},    int'(miso[d]),      0);
    chk({tag, "_oe"},      int'(miso_oe[d]),   0);
    chk({tag, "_addr"},    int'(reg_addr[d]),  0);
    chk({tag, "_wdata"},   int'(wr_data[d]),   0);
    chk({tag, "_wr_en"},   int'(wr_en[d]),     0);
    chk({tag, "_rd_en"},   int'(rd_en[d]),     0);
    chk({tag, "_ferr"},    int'(frame_err[d]), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero(0, "rst_m1");
    chk_zero(1, "rst_m0");
    rst_n = 1'b1;
    #(100);

    // Mode 1 write 0x05 <- 0xA5
    push(1'b0, K_WR, 7'h05, 8'hA5);
    spi_xfer(0, 1'b1, 16, 24'h0005A5, 1'b1, rx);
    chk("wr_miso_quiet", int'(rx[15:0]), 0);
    drain("wr_m1_done");
    chk("wr_addr_hold", int'(reg_addr[0]), 'h05);
    chk("wr_data_hold", int'(wr_data[0]), 'hA5);

    // Mode 1 read 0x03 -> 0x3C
    rd_val = 8'h3C;
    push(1'b0, K_RD, 7'h03, 8'h00);
    spi_xfer(0, 1'b1, 16, 24'h008300, 1'b1, rx);
    chk("rd_m1_cmd_phase", int'(rx[15:8]), 0);
    chk("rd_m1_data", int'(rx[7:0]), 'h3C);
    drain("rd_m1_done");

    // Mode 0 read 0x01 -> 0xC3
    rd_val = 8'hC3;
    push(1'b1, K_RD, 7'h01, 8'h00);
    spi_xfer(1, 1'b0, 16, 24'h008100, 1'b1, rx);
    chk("rd_m0_data", int'(rx[7:0]), 'hC3);
    drain("rd_m0_done");

    // cs_n low with no sclk: nothing happens, no frame error on release
    cs_n[0] = 1'b0;
    #(1000);
    chk("idle_cs_oe", int'(miso_oe[0]), 1);
    chk("idle_cs_addr", int'(reg_addr[0]), 'h03);
    cs_n[0] = 1'b1;
    #(4 * HP);
    drain("idle_cs_done");

    // Abort after 4 data bits of a write to 0x02
    push(1'b0, K_ERR, 7'h00, 8'h00);
    spi_xfer(0, 1'b1, 12, 24'h00002A, 1'b1, rx);
    drain("abort_done");
    chk("abort_no_wdata", int'(wr_data[0]), 'hA5);
    push(1'b0, K_WR, 7'h02, 8'h5A);
    spi_xfer(0, 1'b1, 16, 24'h00025A, 1'b1, rx);
    drain("after_abort_done");

    // Three-byte frame: write 0x7F, 0x11, 0x22
    push(1'b0, K_WR, 7'h7F, 8'h11);
`ifdef SPI_BURST_EN
    push(1'b0, K_WR, 7'h00, 8'h22);
`endif
    spi_xfer(0, 1'b1, 24, 24'h7F1122, 1'b1, rx);
    drain("burst_done");
`ifdef SPI_BURST_EN
    chk("burst_final_addr", int'(reg_addr[0]), 'h01);
`else
    chk("burst_final_addr", int'(reg_addr[0]), 'h7F);
`endif

    // Reset during the data phase of a write
    spi_xfer(0, 1'b1, 11, 24'h000085, 1'b0, rx);
    rst_n = 1'b0;
    #1;
    chk_zero(0, "midrst");
    cs_n[0] = 1'b1;
    #(50);
    rst_n = 1'b1;
    #(100);
    push(1'b0, K_WR, 7'h10, 8'h77);
    spi_xfer(0, 1'b1, 16, 24'h001077, 1'b1, rx);
    drain("post_rst_done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
